// File: rtl/ftq_tage_update_queue_pkg.sv
// Shared defaults and derivations for the FTQ / TAGE update queue.
// Counter constants are computed from the counter width so all users agree.
package ftq_tage_update_queue_pkg;

    localparam int unsigned FTQ_DEF_DEPTH  = 32'd8;
    localparam int unsigned FTQ_DEF_TABLES = 32'd6;
    localparam int unsigned FTQ_DEF_CNTW   = 32'd3;
    localparam int unsigned FTQ_DEF_PCW    = 32'd32;

    typedef enum logic [0:0] {
        ERR_CMT_EMPTY = 1'b0,
        ERR_BAD_REDIR = 1'b1
    } ftq_err_e;

    function automatic int unsigned ftq_iw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned ftq_nw(input int unsigned tables);
        return $clog2(tables + 32'd1);
    endfunction

    function automatic int unsigned ftq_weak_taken(input int unsigned cntw);
        return 32'd1 << (cntw - 32'd1);
    endfunction

    function automatic int unsigned ftq_weak_not_taken(input int unsigned cntw);
        return (32'd1 << (cntw - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/ftq_tage_update_queue_update.sv
// Combinational TAGE update rules for the committing head entry:
// saturating provider/useful arithmetic and lowest-free-table allocation search.
module ftq_update_logic
    import ftq_tage_update_queue_pkg::*;
#(
    parameter int unsigned TABLES = FTQ_DEF_TABLES,
    parameter int unsigned CNTW   = FTQ_DEF_CNTW,
    parameter int unsigned NW     = ftq_nw(TABLES)
)(
    input  logic [NW-1:0]          provider_i,
    input  logic [CNTW-1:0]        prov_ctr_i,
    input  logic [TABLES*CNTW-1:0] useful_i,
    input  logic                   mispred_i,
    input  logic                   taken_i,
    output logic [CNTW-1:0]        prov_ctr_o,
    output logic [TABLES-1:0]      useful_we_o,
    output logic [TABLES*CNTW-1:0] useful_data_o,
    output logic                   alloc_valid_o,
    output logic [NW-1:0]          alloc_table_o,
    output logic [CNTW-1:0]        alloc_ctr_o
);

    localparam logic [CNTW-1:0] CTR_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CTR_WT  = CNTW'(ftq_weak_taken(CNTW));
    localparam logic [CNTW-1:0] CTR_WNT = CNTW'(ftq_weak_not_taken(CNTW));

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == CTR_MAX) ? v : v + CNTW'(1'b1);
    endfunction

    function automatic logic [CNTW-1:0] sat_dec(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b0}}) ? v : v - CNTW'(1'b1);
    endfunction

    logic [CNTW-1:0]   use_s [TABLES];
    logic [CNTW-1:0]   inc_s [TABLES];
    logic [CNTW-1:0]   dec_s [TABLES];
    logic [TABLES-1:0] is_prov_s;
    logic [TABLES-1:0] above_s;
    logic [TABLES-1:0] cand_s;
    logic [NW-1:0]     pick_s;

    for (genvar g = 0; g < TABLES; g++) begin : g_tbl
        assign use_s[g]     = useful_i[g*CNTW +: CNTW];
        assign inc_s[g]     = sat_inc(use_s[g]);
        assign dec_s[g]     = sat_dec(use_s[g]);
        assign is_prov_s[g] = (provider_i == NW'(g + 1));
        assign above_s[g]   = (provider_i < NW'(g + 1));
        assign cand_s[g]    = above_s[g] && (use_s[g] == {CNTW{1'b0}});
    end

    // Update decision: provider counter always, then useful refresh or allocation.
    always_comb begin
        prov_ctr_o    = taken_i ? sat_inc(prov_ctr_i) : sat_dec(prov_ctr_i);
        pick_s        = '0;
        useful_we_o   = '0;
        useful_data_o = '0;
        alloc_valid_o = 1'b0;
        alloc_table_o = '0;
        alloc_ctr_o   = '0;
        // Scan downwards so the lowest eligible table wins.
        for (int t = TABLES - 1; t >= 0; t--) begin
            pick_s = cand_s[t] ? NW'(t + 1) : pick_s;
        end
        if (!mispred_i) begin
            useful_we_o = is_prov_s;
        end else if (provider_i < NW'(TABLES)) begin
            if (|cand_s) begin
                alloc_valid_o = 1'b1;
                alloc_table_o = pick_s;
                alloc_ctr_o   = taken_i ? CTR_WT : CTR_WNT;
            end else begin
                useful_we_o = above_s;
            end
        end else begin
            useful_we_o = '0;
        end
        for (int t = 0; t < TABLES; t++) begin
            useful_data_o[t*CNTW +: CNTW] = useful_we_o[t] ? (mispred_i ? dec_s[t] : inc_s[t])
                                                          : {CNTW{1'b0}};
        end
    end

endmodule

// File: rtl/ftq_tage_update_queue.sv
// Fetch target queue holding TAGE prediction metadata per fetch block; retires
// in order on branch commit and emits registered TAGE update/allocation commands.
module ftq_tage_update_queue
    import ftq_tage_update_queue_pkg::*;
#(
    parameter  int unsigned DEPTH  = FTQ_DEF_DEPTH,
    parameter  int unsigned TABLES = FTQ_DEF_TABLES,
    parameter  int unsigned CNTW   = FTQ_DEF_CNTW,
    parameter  int unsigned PCW    = FTQ_DEF_PCW,
    localparam int unsigned IW     = ftq_iw(DEPTH),
    localparam int unsigned NW     = ftq_nw(TABLES)
)(
    input  logic                   Clk,
    input  logic                   Rest,
    input  logic                   Stop,
    input  logic                   Flush,
    input  logic                   EnqValid,
    output logic                   EnqReady,
    input  logic [NW-1:0]          EnqProvider,
    input  logic [CNTW-1:0]        EnqProvCtr,
    input  logic [TABLES*CNTW-1:0] EnqUseful,
    output logic [IW-1:0]          EnqIdx,
    input  logic                   CmtValid,
    input  logic                   CmtMispred,
    input  logic                   CmtTaken,
    input  logic [PCW-1:0]         CmtPc,
    input  logic                   RedirValid,
    input  logic [IW-1:0]          RedirIdx,
    output logic                   Full,
    output logic                   Empty,
    output logic [IW:0]            Count,
    output logic                   UpdValid,
    output logic [PCW-1:0]         UpdPc,
    output logic [NW-1:0]          UpdProvider,
    output logic [CNTW-1:0]        UpdProvCtr,
    output logic [TABLES-1:0]      UsefulWe,
    output logic [TABLES*CNTW-1:0] UsefulData,
    output logic                   AllocValid,
    output logic [NW-1:0]          AllocTable,
    output logic [CNTW-1:0]        AllocCtr,
    output logic [1:0]             ErrSticky
);

    localparam logic [IW:0] PTR_ONE = {{IW{1'b0}}, 1'b1};

    logic [NW-1:0]          prov_mem_q   [DEPTH];
    logic [CNTW-1:0]        ctr_mem_q    [DEPTH];
    logic [TABLES*CNTW-1:0] useful_mem_q [DEPTH];

    logic [IW:0] head_q, head_d, tail_q, tail_d, count_s;
    logic [1:0]  err_q, err_d;
    logic [IW-1:0] redir_off_s;
    logic full_s, empty_s, enq_fire_s, cmt_fire_s, upd_fire_s, wr_en_s, redir_ok_s;

    logic [CNTW-1:0]        lg_ctr_s;
    logic [TABLES-1:0]      lg_we_s;
    logic [TABLES*CNTW-1:0] lg_data_s;
    logic                   lg_av_s;
    logic [NW-1:0]          lg_at_s;
    logic [CNTW-1:0]        lg_ac_s;

    logic                   upd_valid_q, alloc_valid_q;
    logic [PCW-1:0]         upd_pc_q;
    logic [NW-1:0]          upd_prov_q, alloc_table_q;
    logic [CNTW-1:0]        upd_ctr_q, alloc_ctr_q;
    logic [TABLES-1:0]      useful_we_q;
    logic [TABLES*CNTW-1:0] useful_data_q;

    // Occupancy, handshakes and redirect range check from the current pointers.
    always_comb begin
        count_s     = tail_q - head_q;
        empty_s     = (head_q == tail_q);
        full_s      = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
        enq_fire_s  = EnqValid && !full_s && !Stop;
        cmt_fire_s  = CmtValid && !empty_s;
        upd_fire_s  = cmt_fire_s && !Flush;
        wr_en_s     = enq_fire_s && !Flush && !RedirValid;
        redir_off_s = RedirIdx - head_q[IW-1:0];
        redir_ok_s  = ({1'b0, redir_off_s} < count_s);
    end

    // Pointer and error next state; Flush beats Redirect beats Enqueue.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        err_d  = err_q;
        if (CmtValid && empty_s) begin
            err_d[ERR_CMT_EMPTY] = 1'b1;
        end else begin
            err_d[ERR_CMT_EMPTY] = err_q[ERR_CMT_EMPTY];
        end
        if (Flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            head_d = cmt_fire_s ? head_q + PTR_ONE : head_q;
            if (RedirValid) begin
                if (redir_ok_s) begin
                    tail_d = head_q + {1'b0, redir_off_s} + PTR_ONE;
                end else begin
                    err_d[ERR_BAD_REDIR] = 1'b1;
                end
            end else if (wr_en_s) begin
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // Pointer and sticky error registers.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            head_q <= '0;
            tail_q <= '0;
            err_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

    // Entry storage is written on enqueue only and carries no reset.
    always_ff @(posedge Clk) begin
        if (wr_en_s) begin
            prov_mem_q[tail_q[IW-1:0]]   <= EnqProvider;
            ctr_mem_q[tail_q[IW-1:0]]    <= EnqProvCtr;
            useful_mem_q[tail_q[IW-1:0]] <= EnqUseful;
        end
    end

    ftq_update_logic #(
        .TABLES (TABLES),
        .CNTW   (CNTW),
        .NW     (NW)
    ) u_update (
        .provider_i    (prov_mem_q[head_q[IW-1:0]]),
        .prov_ctr_i    (ctr_mem_q[head_q[IW-1:0]]),
        .useful_i      (useful_mem_q[head_q[IW-1:0]]),
        .mispred_i     (CmtMispred),
        .taken_i       (CmtTaken),
        .prov_ctr_o    (lg_ctr_s),
        .useful_we_o   (lg_we_s),
        .useful_data_o (lg_data_s),
        .alloc_valid_o (lg_av_s),
        .alloc_table_o (lg_at_s),
        .alloc_ctr_o   (lg_ac_s)
    );

    // Registered update command; every field returns to zero between strobes.
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_prov_q    <= '0;
            upd_ctr_q     <= '0;
            useful_we_q   <= '0;
            useful_data_q <= '0;
            alloc_valid_q <= 1'b0;
            alloc_table_q <= '0;
            alloc_ctr_q   <= '0;
        end else begin
            upd_valid_q   <= upd_fire_s;
            upd_pc_q      <= upd_fire_s ? CmtPc : '0;
            upd_prov_q    <= upd_fire_s ? prov_mem_q[head_q[IW-1:0]] : '0;
            upd_ctr_q     <= upd_fire_s ? lg_ctr_s : '0;
            useful_we_q   <= upd_fire_s ? lg_we_s : '0;
            useful_data_q <= upd_fire_s ? lg_data_s : '0;
            alloc_valid_q <= upd_fire_s && lg_av_s;
            alloc_table_q <= upd_fire_s ? lg_at_s : '0;
            alloc_ctr_q   <= upd_fire_s ? lg_ac_s : '0;
        end
    end

    assign EnqReady    = !full_s && !Stop;
    assign EnqIdx      = tail_q[IW-1:0];
    assign Full        = full_s;
    assign Empty       = empty_s;
    assign Count       = count_s;
    assign ErrSticky   = err_q;
    assign UpdValid    = upd_valid_q;
    assign UpdPc       = upd_pc_q;
    assign UpdProvider = upd_prov_q;
    assign UpdProvCtr  = upd_ctr_q;
    assign UsefulWe    = useful_we_q;
    assign UsefulData  = useful_data_q;
    assign AllocValid  = alloc_valid_q;
    assign AllocTable  = alloc_table_q;
    assign AllocCtr    = alloc_ctr_q;

endmodule

// File: tb/tb_ftq_tage_update_queue.sv
// Directed vector table for the documented corner cases, then random traffic
// checked against a queue-based model of the FTQ and TAGE update rules.
module tb_ftq_tage_update_queue;

    localparam int DEPTH = 8, TABLES = 6, CNTW = 3, PCW = 32, IW = 3, NW = 3;
    localparam int CMAX = (1 << CNTW) - 1;

    logic Clk = 1'b0;
    logic Rest, Stop, Flush, EnqValid, EnqReady, CmtValid, CmtMispred, CmtTaken, RedirValid;
    logic Full, Empty, UpdValid, AllocValid;
    logic [NW-1:0] EnqProvider, UpdProvider, AllocTable;
    logic [CNTW-1:0] EnqProvCtr, UpdProvCtr, AllocCtr;
    logic [TABLES*CNTW-1:0] EnqUseful, UsefulData;
    logic [IW-1:0] EnqIdx, RedirIdx;
    logic [PCW-1:0] CmtPc, UpdPc;
    logic [IW:0] Count;
    logic [TABLES-1:0] UsefulWe;
    logic [1:0] ErrSticky;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    ftq_tage_update_queue #(.DEPTH(DEPTH), .TABLES(TABLES), .CNTW(CNTW), .PCW(PCW)) dut (
        .Clk(Clk), .Rest(Rest), .Stop(Stop), .Flush(Flush), .EnqValid(EnqValid),
        .EnqReady(EnqReady), .EnqProvider(EnqProvider), .EnqProvCtr(EnqProvCtr),
        .EnqUseful(EnqUseful), .EnqIdx(EnqIdx), .CmtValid(CmtValid), .CmtMispred(CmtMispred),
        .CmtTaken(CmtTaken), .CmtPc(CmtPc), .RedirValid(RedirValid), .RedirIdx(RedirIdx),
        .Full(Full), .Empty(Empty), .Count(Count), .UpdValid(UpdValid), .UpdPc(UpdPc),
        .UpdProvider(UpdProvider), .UpdProvCtr(UpdProvCtr), .UsefulWe(UsefulWe),
        .UsefulData(UsefulData), .AllocValid(AllocValid), .AllocTable(AllocTable),
        .AllocCtr(AllocCtr), .ErrSticky(ErrSticky)
    );

    typedef struct {
        bit s, f, e; int pv, ct; logic [17:0] us; bit c, m, t, r; int ri;
        int cnt; bit uv; int uc; logic [5:0] we; logic [17:0] ud; bit av; int at, ac; logic [1:0] er;
    } vec_t;
    vec_t vt[$];

    typedef struct packed { logic [2:0] prov; logic [2:0] ctr; logic [17:0] u; } ent_t;
    typedef struct packed {
        logic v; logic [31:0] pc; logic [2:0] prov; logic [2:0] ctr;
        logic [5:0] we; logic [17:0] ud; logic av; logic [2:0] at; logic [2:0] ac;
    } upd_t;

    ent_t mq[$];
    int m_head;
    logic [1:0] m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit s, f, e, input int pv, ct, input logic [17:0] us,
                       input bit c, m, t, r, input int ri, input int cnt, input bit uv,
                       input int uc, input logic [5:0] we, input logic [17:0] ud,
                       input bit av, input int at, ac, input logic [1:0] er);
        vec_t v;
        v.s = s; v.f = f; v.e = e; v.pv = pv; v.ct = ct; v.us = us; v.c = c; v.m = m; v.t = t;
        v.r = r; v.ri = ri; v.cnt = cnt; v.uv = uv; v.uc = uc; v.we = we; v.ud = ud;
        v.av = av; v.at = at; v.ac = ac; v.er = er;
        vt.push_back(v);
    endtask

    function automatic int uget(logic [17:0] u, int t);
        return int'((u >> (3 * (t - 1))) & 18'h7);
    endfunction

    // Spec rules evaluated directly with integer arithmetic.
    function automatic upd_t model_upd(ent_t e, bit mis, bit tk, logic [31:0] pc);
        upd_t r;
        int p, c, uu, first;
        r = '0; r.v = 1'b1; r.pc = pc; r.prov = e.prov;
        p = int'(e.prov);
        c = tk ? int'(e.ctr) + 1 : int'(e.ctr) - 1;
        if (c > CMAX) c = CMAX;
        if (c < 0) c = 0;
        r.ctr = c[2:0];
        if (!mis) begin
            if (p >= 1 && p <= TABLES) begin
                uu = uget(e.u, p) + 1;
                if (uu > CMAX) uu = CMAX;
                r.we[p-1] = 1'b1;
                r.ud = 18'(uu) << (3 * (p - 1));
            end
        end else if (p < TABLES) begin
            first = 0;
            for (int t = p + 1; t <= TABLES; t++)
                if (first == 0 && uget(e.u, t) == 0) first = t;
            if (first != 0) begin
                r.av = 1'b1; r.at = first[2:0]; r.ac = tk ? 3'd4 : 3'd3;
            end else begin
                for (int t = p + 1; t <= TABLES; t++) begin
                    uu = uget(e.u, t) - 1;
                    if (uu < 0) uu = 0;
                    r.we[t-1] = 1'b1;
                    r.ud = r.ud | (18'(uu) << (3 * (t - 1)));
                end
            end
        end
        return r;
    endfunction

    task automatic idle_inputs();
        Stop = 1'b0; Flush = 1'b0; EnqValid = 1'b0; EnqProvider = '0; EnqProvCtr = '0;
        EnqUseful = '0; CmtValid = 1'b0; CmtMispred = 1'b0; CmtTaken = 1'b0; CmtPc = '0;
        RedirValid = 1'b0; RedirIdx = '0;
    endtask

    task automatic rand_cycle();
        ent_t ne;
        upd_t eu;
        int off, sz;
        bit enq_ok, cmt_ok;
        Stop = ($urandom_range(0, 4) == 0);
        Flush = ($urandom_range(0, 39) == 0);
        EnqValid = ($urandom_range(0, 9) < 6);
        CmtValid = ($urandom_range(0, 9) < 4);
        CmtMispred = $urandom_range(0, 1) == 1;
        CmtTaken = $urandom_range(0, 1) == 1;
        CmtPc = $urandom;
        RedirValid = ($urandom_range(0, 19) == 0);
        RedirIdx = 3'($urandom_range(0, 7));
        ne.prov = 3'($urandom_range(0, TABLES));
        ne.ctr = 3'($urandom_range(0, 7));
        for (int t = 0; t < TABLES; t++)
            ne.u[3*t +: 3] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
        EnqProvider = ne.prov; EnqProvCtr = ne.ctr; EnqUseful = ne.u;
        eu = '0;
        sz = mq.size();
        enq_ok = EnqValid && !Stop && sz < DEPTH;
        cmt_ok = CmtValid && sz > 0;
        if (CmtValid && sz == 0) m_err[0] = 1'b1;
        if (Flush) begin
            mq.delete(); m_head = 0;
        end else begin
            if (cmt_ok) eu = model_upd(mq[0], CmtMispred, CmtTaken, CmtPc);
            if (RedirValid) begin
                off = (int'(RedirIdx) - m_head + DEPTH) % DEPTH;
                if (off < sz) begin
                    while (mq.size() > off + 1) void'(mq.pop_back());
                end else begin
                    m_err[1] = 1'b1;
                end
            end else if (enq_ok) begin
                mq.push_back(ne);
            end
            if (cmt_ok) begin
                void'(mq.pop_front()); m_head = (m_head + 1) % DEPTH;
            end
        end
        @(posedge Clk); #1;
        sz = mq.size();
        chk("count", 64'(Count), 64'(sz));
        chk("full", 64'(Full), 64'(sz == DEPTH));
        chk("empty", 64'(Empty), 64'(sz == 0));
        chk("enq_ready", 64'(EnqReady), 64'(sz < DEPTH && !Stop));
        chk("enq_idx", 64'(EnqIdx), 64'((m_head + sz) % DEPTH));
        chk("err", 64'(ErrSticky), 64'(m_err));
        chk("upd_valid", 64'(UpdValid), 64'(eu.v));
        chk("useful_we", 64'(UsefulWe), 64'(eu.we));
        chk("alloc_valid", 64'(AllocValid), 64'(eu.av));
        if (eu.v) begin
            chk("upd_pc", 64'(UpdPc), 64'(eu.pc));
            chk("upd_prov", 64'(UpdProvider), 64'(eu.prov));
            chk("upd_ctr", 64'(UpdProvCtr), 64'(eu.ctr));
            chk("useful_data", 64'(UsefulData), 64'(eu.ud));
            if (eu.av) begin
                chk("alloc_table", 64'(AllocTable), 64'(eu.at));
                chk("alloc_ctr", 64'(AllocCtr), 64'(eu.ac));
            end
        end
    endtask

    initial begin
        idle_inputs();
        Rest = 1'b1;
        // Directed vectors: inputs for one cycle, then expected state after the edge.
        add(0,0,0, 0,0,18'h0,     1,0,0, 0,0, 0, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,0,1, 2,7,18'h00018, 0,0,0, 0,0, 1, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,0,1, 1,2,18'h09209, 0,0,0, 0,0, 2, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,0,1, 0,0,18'h09249, 0,0,0, 0,0, 3, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        for (int k = 4; k <= 8; k++)
            add(0,0,1, 6,5,18'h0, 0,0,0, 0,0, k, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,0,1, 6,5,18'h0,     0,0,0, 0,0, 8, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,0,0, 0,0,18'h0,     1,0,1, 0,0, 7, 1,7,6'h02,18'h00020, 0,0,0, 2'b01);
        add(0,0,0, 0,0,18'h0,     1,1,1, 0,0, 6, 1,3,6'h00,18'h0,     1,3,4, 2'b01);
        add(0,0,0, 0,0,18'h0,     1,1,0, 0,0, 5, 1,0,6'h3F,18'h0,     0,0,0, 2'b01);
        add(0,0,0, 0,0,18'h0,     0,0,0, 0,0, 5, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,1,1, 3,3,18'h3FFFF, 0,0,0, 0,0, 0, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        for (int k = 1; k <= 5; k++)
            add(0,0,1, 6,5,18'h0, 0,0,0, 0,0, k, 0,0,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,0,0, 0,0,18'h0,     1,1,1, 1,2, 2, 1,6,6'h00,18'h0,     0,0,0, 2'b01);
        add(0,0,0, 0,0,18'h0,     0,0,0, 1,6, 2, 0,0,6'h00,18'h0,     0,0,0, 2'b11);
        add(1,0,1, 6,5,18'h0,     0,0,0, 0,0, 2, 0,0,6'h00,18'h0,     0,0,0, 2'b11);
        add(0,0,1, 3,1,18'h0,     1,0,0, 0,0, 2, 1,4,6'h20,18'h08000, 0,0,0, 2'b11);
        add(0,0,0, 0,0,18'h0,     1,1,1, 0,0, 1, 1,6,6'h00,18'h0,     0,0,0, 2'b11);
        add(0,0,0, 0,0,18'h0,     1,1,0, 0,0, 0, 1,0,6'h00,18'h0,     1,4,3, 2'b11);
        add(0,0,0, 0,0,18'h0,     0,0,0, 0,0, 0, 0,0,6'h00,18'h0,     0,0,0, 2'b11);

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_full", 64'(Full), 64'd0);
        chk("rst_enq_idx", 64'(EnqIdx), 64'd0);
        chk("rst_upd_valid", 64'(UpdValid), 64'd0);
        chk("rst_alloc_valid", 64'(AllocValid), 64'd0);
        chk("rst_useful_we", 64'(UsefulWe), 64'd0);
        chk("rst_err", 64'(ErrSticky), 64'd0);
        Rest = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            Stop = vt[i].s; Flush = vt[i].f; EnqValid = vt[i].e;
            EnqProvider = 3'(vt[i].pv); EnqProvCtr = 3'(vt[i].ct); EnqUseful = vt[i].us;
            CmtValid = vt[i].c; CmtMispred = vt[i].m; CmtTaken = vt[i].t;
            CmtPc = 32'h1000 + 32'(i * 4);
            RedirValid = vt[i].r; RedirIdx = 3'(vt[i].ri);
            @(posedge Clk); #1;
            chk($sformatf("v%0d_count", i), 64'(Count), 64'(vt[i].cnt));
            chk($sformatf("v%0d_full", i), 64'(Full), 64'(vt[i].cnt == DEPTH));
            chk($sformatf("v%0d_empty", i), 64'(Empty), 64'(vt[i].cnt == 0));
            chk($sformatf("v%0d_ready", i), 64'(EnqReady), 64'(vt[i].cnt != DEPTH && !vt[i].s));
            chk($sformatf("v%0d_err", i), 64'(ErrSticky), 64'(vt[i].er));
            chk($sformatf("v%0d_upd_valid", i), 64'(UpdValid), 64'(vt[i].uv));
            chk($sformatf("v%0d_useful_we", i), 64'(UsefulWe), 64'(vt[i].we));
            chk($sformatf("v%0d_alloc_valid", i), 64'(AllocValid), 64'(vt[i].av));
            if (vt[i].uv) begin
                chk($sformatf("v%0d_upd_pc", i), 64'(UpdPc), 64'(CmtPc));
                chk($sformatf("v%0d_upd_ctr", i), 64'(UpdProvCtr), 64'(vt[i].uc));
                chk($sformatf("v%0d_useful_data", i), 64'(UsefulData), 64'(vt[i].ud));
            end
            if (vt[i].av) begin
                chk($sformatf("v%0d_alloc_table", i), 64'(AllocTable), 64'(vt[i].at));
                chk($sformatf("v%0d_alloc_ctr", i), 64'(AllocCtr), 64'(vt[i].ac));
            end
        end

        idle_inputs();
        Rest = 1'b1;
        #3;
        chk("rst2_err", 64'(ErrSticky), 64'd0);
        chk("rst2_count", 64'(Count), 64'd0);
        @(posedge Clk); #1;
        Rest = 1'b0;
        mq.delete(); m_head = 0; m_err = 2'b00;
        for (int n = 0; n < 3000; n++) rand_cycle();

        // Asynchronous reset must kill an in-flight update strobe.
        idle_inputs();
        EnqValid = 1'b1;
        @(posedge Clk); #1;
        EnqValid = 1'b0;
        CmtValid = 1'b1;
        @(posedge Clk); #1;
        CmtValid = 1'b0;
        chk("pre_async_upd_valid", 64'(UpdValid), 64'd1);
        #2;
        Rest = 1'b1;
        #1;
        chk("async_upd_valid", 64'(UpdValid), 64'd0);
        chk("async_count", 64'(Count), 64'd0);
        chk("async_empty", 64'(Empty), 64'd1);
        chk("async_err", 64'(ErrSticky), 64'd0);
        #10;
        Rest = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
